spi_shift_datapath: RTL and testbench
=====================================

Name: spi_shift_datapath

Overview:
- Bit-level SPI datapath beside the SPI controller: consumes its SCLK, load strobe and frame-active indication; serialises TX FIFO words onto MOSI; deserialises MISO into RX words.
- Supports all four CPOL/CPHA modes and 1..8-bit frames.
- Produces its own one-cycle RX word strobe for the RX FIFO, plus a sticky overrun flag.

Parameters:
- DATA_W, 8, shift register and FIFO word width; frame length is never larger than this.

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset, asynchronous, active-low
- tx_load  in  1  one-cycle load strobe (controller TX FIFO read); tx_data is valid in the same cycle
- tx_data  in  DATA_W  TX FIFO head word (show-ahead)
- spi_clk_i  in  1  SCLK from the controller
- spi_active_i  in  1  high while the controller is in its transfer state
- spi_clk_polarity  in  1  CPOL
- spi_clk_phase  in  1  CPHA
- spi_data_size  in  4  frame length N
- miso_i  in  1  serial input
- mosi_o  out  1  serial output, registered
- rx_data_o  out  DATA_W  last received word, right-justified, held until the next capture
- rx_valid_o  out  1  one-cycle RX FIFO write strobe
- rx_fifo_full  in  1  RX FIFO full
- rx_overrun_o  out  1  sticky overrun flag
- rx_overrun_clr  in  1  clears rx_overrun_o
- bit_cnt_o  out  4  bits sampled in the current frame

Behaviour:
- Reset values: all outputs 0; sclk_q = 0; state DP_IDLE.
- Frame length N = spi_data_size when 1..DATA_W; otherwise (0 or >DATA_W) N = DATA_W. N is latched on tx_load.
- Edge detect uses sclk_q, the registered spi_clk_i:
  - leading = sclk_q==CPOL && spi_clk_i!=CPOL
  - trailing = sclk_q!=CPOL && spi_clk_i==CPOL
  - Edge actions occur in the cycle the edge is seen; this is one cycle after the controller toggles SCLK.
- FSM states: DP_IDLE, DP_ARMED, DP_SHIFT, DP_CAPTURE.
- tx_load from any state:
  - tx_shift <= tx_data; bit_cnt <= 0; go to DP_ARMED.
  - CPHA=0: mosi_o <= first bit next cycle.
  - CPHA=1: mosi_o is unchanged until the first leading edge.
- DP_ARMED -> DP_SHIFT on the first edge seen while spi_active_i=1. That edge is processed normally.
- Edge actions in DP_ARMED/DP_SHIFT:
  - CPHA=0: leading edge samples miso_i and increments bit_cnt. Trailing edge drives the next bit, suppressed once bit_cnt==N.
  - CPHA=1: leading edge drives the next bit. Trailing edge samples miso_i and increments bit_cnt.
- When bit_cnt reaches N, go to DP_CAPTURE on the next cycle. In DP_CAPTURE:
  - rx_data_o <= assembled word, bits above N-1 zero.
  - rx_valid_o = 1 for exactly that cycle.
  - Return to DP_IDLE; a tx_load arriving in the same cycle wins and goes to DP_ARMED.
- Overrun: rx_valid_o with rx_fifo_full=1 sets rx_overrun_o. rx_valid is still pulsed; the FIFO drops the word.
  - Set and clear in the same cycle: set wins.
- Abort: spi_active_i falling while in DP_SHIFT with bit_cnt<N -> DP_IDLE, no rx_valid_o, mosi_o <= 0, partial word discarded.
- In DP_IDLE: edges are ignored and mosi_o <= 0.
- bit_cnt saturates at N; it never wraps.
- Reset mid-frame: everything returns to reset values immediately (asynchronous); no strobe is emitted.
- Back-to-back frames (controller turnaround): a tx_load during DP_CAPTURE or DP_IDLE starts the next frame with no lost cycle.

Optional Feature:
- Macro: SPI_LSB_FIRST_EN.
- Defined: TX sends tx_data[0] first. RX shifts in at bit DATA_W-1, moving right; at capture the word is shifted right by DATA_W-N, so it stays right-justified with the first bit at bit 0.
- Undefined: MSB-first only. TX sends tx_data[N-1] first; RX shifts in at bit 0, moving left, so the first bit ends at bit N-1.

Test Plan:
- Mode 0 (CPOL=0, CPHA=0), N=8, tx_data=0xA5, MISO loopback of MOSI -> MOSI bit sequence 1,0,1,0,0,1,0,1; rx_data_o=0xA5; one rx_valid_o pulse.
- Mode 3 (CPOL=1, CPHA=1), N=5, tx_data=0x13, miso_i fixed at 1 -> MOSI 1,0,0,1,1; rx_data_o=0x1F; bit_cnt_o reaches 5 and holds.
- spi_data_size=0 -> behaves as N=8. spi_data_size=12 -> N=8.
- Two frames via tx_load in the DP_CAPTURE cycle, words 0x3C then 0xC3, loopback -> two rx_valid_o pulses with 0x3C and 0xC3, no missing edge.
- rx_fifo_full=1 at capture -> rx_overrun_o=1 and stays set; rx_overrun_clr pulse -> 0.
- Abort: spi_active_i dropped after 3 samples -> no rx_valid_o, mosi_o=0, state DP_IDLE.
- With SPI_LSB_FIRST_EN, mode 1, N=4, tx_data=0x6, loopback -> MOSI 0,1,1,0; rx_data_o=0x6.

Source files
------------

// File: rtl/spi_shift_datapath.sv
// Bit-level SPI shift datapath: serialises TX words onto MOSI and assembles MISO into RX words.
// Optional macro SPI_LSB_FIRST_EN selects LSB-first framing; default build is MSB-first only.
module spi_shift_datapath #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              tx_load,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              spi_clk_i,
  input  logic              spi_active_i,
  input  logic              spi_clk_polarity,
  input  logic              spi_clk_phase,
  input  logic [3:0]        spi_data_size,
  input  logic              miso_i,
  output logic              mosi_o,
  output logic [DATA_W-1:0] rx_data_o,
  output logic              rx_valid_o,
  input  logic              rx_fifo_full,
  output logic              rx_overrun_o,
  input  logic              rx_overrun_clr,
  output logic [3:0]        bit_cnt_o
);

  typedef enum logic [1:0] {DP_IDLE, DP_ARMED, DP_SHIFT, DP_CAPTURE} dp_state_t;

  localparam logic [3:0] MAX_LEN = 4'(DATA_W);

  dp_state_t         state;
  logic              sclk_q;
  logic [3:0]        frame_len;
  logic [3:0]        bit_cnt;
  logic [3:0]        len_sel;
  logic [DATA_W-1:0] tx_shift;
  logic [DATA_W-1:0] rx_shift;
  logic [DATA_W-1:0] tx_aligned;
  logic [DATA_W-1:0] tx_aligned_adv;
  logic [DATA_W-1:0] tx_shift_next;
  logic [DATA_W-1:0] rx_shift_next;
  logic [DATA_W-1:0] rx_word;
  logic              tx_first;
  logic              tx_next_bit;
  logic              leading;
  logic              trailing;
  logic              sample_edge;
  logic              drive_edge;
  logic              cnt_full;

  assign len_sel = (spi_data_size == 4'd0 || spi_data_size > MAX_LEN) ? MAX_LEN : spi_data_size;

  assign leading     = (sclk_q == spi_clk_polarity) && (spi_clk_i != spi_clk_polarity);
  assign trailing    = (sclk_q != spi_clk_polarity) && (spi_clk_i == spi_clk_polarity);
  assign sample_edge = spi_clk_phase ? trailing : leading;
  assign drive_edge  = spi_clk_phase ? leading : trailing;
  assign cnt_full    = (bit_cnt == frame_len);
  assign bit_cnt_o   = bit_cnt;

`ifdef SPI_LSB_FIRST_EN
  // The first bit enters at the top and walks down, so a short frame is realigned at capture.
  assign tx_aligned     = tx_data;
  assign tx_first       = tx_aligned[0];
  assign tx_aligned_adv = tx_aligned >> 1;
  assign tx_next_bit    = tx_shift[0];
  assign tx_shift_next  = tx_shift >> 1;
  assign rx_shift_next  = {miso_i, rx_shift[DATA_W-1:1]};
  assign rx_word        = rx_shift >> (MAX_LEN - frame_len);
`else
  // TX word is pre-aligned so bit N-1 always leaves from the top of the register.
  assign tx_aligned     = tx_data << (MAX_LEN - len_sel);
  assign tx_first       = tx_aligned[DATA_W-1];
  assign tx_aligned_adv = tx_aligned << 1;
  assign tx_next_bit    = tx_shift[DATA_W-1];
  assign tx_shift_next  = tx_shift << 1;
  assign rx_shift_next  = {rx_shift[DATA_W-2:0], miso_i};
  assign rx_word        = rx_shift;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= DP_IDLE;
      sclk_q       <= 1'b0;
      frame_len    <= MAX_LEN;
      bit_cnt      <= 4'd0;
      tx_shift     <= '0;
      rx_shift     <= '0;
      mosi_o       <= 1'b0;
      rx_data_o    <= '0;
      rx_valid_o   <= 1'b0;
      rx_overrun_o <= 1'b0;
    end else begin
      sclk_q     <= spi_clk_i;
      rx_valid_o <= 1'b0;

      if (rx_valid_o && rx_fifo_full)
        rx_overrun_o <= 1'b1;
      else if (rx_overrun_clr)
        rx_overrun_o <= 1'b0;

      if (tx_load) begin
        state     <= DP_ARMED;
        frame_len <= len_sel;
        bit_cnt   <= 4'd0;
        rx_shift  <= '0;
        if (!spi_clk_phase) begin
          mosi_o   <= tx_first;
          tx_shift <= tx_aligned_adv;
        end else begin
          tx_shift <= tx_aligned;
        end
      end else begin
        unique case (state)
          DP_IDLE: mosi_o <= 1'b0;
          DP_ARMED, DP_SHIFT: begin
            // A full count blocks further edges, which both saturates bit_cnt and suppresses the extra drive.
            if (cnt_full) begin
              state      <= DP_CAPTURE;
              rx_data_o  <= rx_word;
              rx_valid_o <= 1'b1;
            end else if (state == DP_SHIFT && !spi_active_i) begin
              state    <= DP_IDLE;
              mosi_o   <= 1'b0;
              rx_shift <= '0;
            end else if (spi_active_i && (leading || trailing)) begin
              state <= DP_SHIFT;
              if (sample_edge) begin
                rx_shift <= rx_shift_next;
                bit_cnt  <= bit_cnt + 4'd1;
              end
              if (drive_edge) begin
                mosi_o   <= tx_next_bit;
                tx_shift <= tx_shift_next;
              end
            end
          end
          DP_CAPTURE: state <= DP_IDLE;
          default:    state <= DP_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_spi_shift_datapath.sv
// Directed bench for spi_shift_datapath: plays the SPI controller's SCLK/load/active sequencing.
// Expected MOSI order for the 5-bit frame depends on SPI_LSB_FIRST_EN.
module tb_spi_shift_datapath;

  localparam int DATA_W = 8;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              tx_load;
  logic [DATA_W-1:0] tx_data;
  logic              spi_clk_i;
  logic              spi_active_i;
  logic              cpol;
  logic              cpha;
  logic [3:0]        spi_data_size;
  logic              miso_fixed;
  logic              loopback;
  wire               miso_i;
  logic              mosi_o;
  logic [DATA_W-1:0] rx_data_o;
  logic              rx_valid_o;
  logic              rx_fifo_full;
  logic              rx_overrun_o;
  logic              rx_overrun_clr;
  logic [3:0]        bit_cnt_o;

  int          total = 0;
  int          bad = 0;
  int          valid_cnt = 0;
  int          v0;
  logic [7:0]  last_rx = 8'h00;
  logic [7:0]  mosi_seq;
  logic [7:0]  seq_first;
  logic [7:0]  exp_seq13;

  spi_shift_datapath #(.DATA_W(DATA_W)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .tx_load          (tx_load),
    .tx_data          (tx_data),
    .spi_clk_i        (spi_clk_i),
    .spi_active_i     (spi_active_i),
    .spi_clk_polarity (cpol),
    .spi_clk_phase    (cpha),
    .spi_data_size    (spi_data_size),
    .miso_i           (miso_i),
    .mosi_o           (mosi_o),
    .rx_data_o        (rx_data_o),
    .rx_valid_o       (rx_valid_o),
    .rx_fifo_full     (rx_fifo_full),
    .rx_overrun_o     (rx_overrun_o),
    .rx_overrun_clr   (rx_overrun_clr),
    .bit_cnt_o        (bit_cnt_o)
  );

  always #5 clk = ~clk;

  assign miso_i = loopback ? mosi_o : miso_fixed;

  // Strobe monitor: each cycle with rx_valid_o high counts as one delivered word.
  always @(negedge clk) begin
    if (rx_valid_o === 1'b1) begin
      valid_cnt = valid_cnt + 1;
      last_rx   = rx_data_o;
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [7:0] observed, input logic [7:0] expected);
    total = total + 1;
    assert (observed === expected)
    else begin
      bad = bad + 1;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic start_frame(input logic pol, input logic pha, input logic [3:0] size, input logic [7:0] data);
    spi_active_i = 1'b0;
    cpol         = pol;
    cpha         = pha;
    spi_clk_i    = pol;
    tick;
    tick;
    tx_data       = data;
    spi_data_size = size;
    tx_load       = 1'b1;
    tick;
    tx_load      = 1'b0;
    spi_active_i = 1'b1;
    mosi_seq     = 8'h00;
  endtask

  // Each bit: two cycles, leading toggle, two cycles, trailing toggle. MOSI is recorded as the DUT samples it.
  task automatic run_edges(input int nb);
    for (int i = 0; i < nb; i++) begin
      tick;
      tick;
      spi_clk_i = ~spi_clk_i;
      if (!cpha) mosi_seq = {mosi_seq[6:0], mosi_o};
      tick;
      tick;
      spi_clk_i = ~spi_clk_i;
      if (cpha) mosi_seq = {mosi_seq[6:0], mosi_o};
    end
  endtask

  task automatic finish_frame;
    repeat (4) tick;
    spi_active_i = 1'b0;
    tick;
  endtask

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1, "[TB] watchdog");
  end

  initial begin
`ifdef SPI_LSB_FIRST_EN
    exp_seq13 = 8'h19;
`else
    exp_seq13 = 8'h13;
`endif
    rst_n          = 1'b0;
    tx_load        = 1'b0;
    tx_data        = 8'h00;
    spi_clk_i      = 1'b0;
    spi_active_i   = 1'b0;
    cpol           = 1'b0;
    cpha           = 1'b0;
    spi_data_size  = 4'd8;
    miso_fixed     = 1'b0;
    loopback       = 1'b1;
    rx_fifo_full   = 1'b0;
    rx_overrun_clr = 1'b0;
    mosi_seq       = 8'h00;
    tick;
    tick;
    check("reset mosi", {7'b0, mosi_o}, 8'h00);
    check("reset rx_data", rx_data_o, 8'h00);
    check("reset rx_valid", {7'b0, rx_valid_o}, 8'h00);
    check("reset overrun", {7'b0, rx_overrun_o}, 8'h00);
    check("reset bit_cnt", {4'b0, bit_cnt_o}, 8'h00);
    rst_n = 1'b1;
    tick;

    $display("[TB] mode 0, N=8, 0xA5 loopback");
    v0 = valid_cnt;
    start_frame(1'b0, 1'b0, 4'd8, 8'hA5);
    run_edges(8);
    finish_frame;
    check("m0 mosi seq", mosi_seq, 8'hA5);
    check("m0 rx_data", last_rx, 8'hA5);
    check("m0 pulses", 8'(valid_cnt - v0), 8'd1);
    check("m0 idle mosi", {7'b0, mosi_o}, 8'h00);

    $display("[TB] mode 3, N=5, 0x13, miso high");
    loopback   = 1'b0;
    miso_fixed = 1'b1;
    v0 = valid_cnt;
    start_frame(1'b1, 1'b1, 4'd5, 8'h13);
    run_edges(5);
    finish_frame;
    check("m3 mosi seq", mosi_seq, exp_seq13);
    check("m3 rx_data", last_rx, 8'h1F);
    check("m3 pulses", 8'(valid_cnt - v0), 8'd1);
    check("m3 bit_cnt", {4'b0, bit_cnt_o}, 8'd5);
    spi_active_i = 1'b1;
    run_edges(2);
    tick;
    tick;
    check("m3 bit_cnt hold", {4'b0, bit_cnt_o}, 8'd5);
    check("m3 no extra pulse", 8'(valid_cnt - v0), 8'd1);
    spi_active_i = 1'b0;
    loopback     = 1'b1;
    miso_fixed   = 1'b0;

    $display("[TB] size 0 and size 12 map to 8 bits");
    v0 = valid_cnt;
    start_frame(1'b0, 1'b0, 4'd0, 8'h5A);
    run_edges(8);
    finish_frame;
    check("size0 rx_data", last_rx, 8'h5A);
    check("size0 bit_cnt", {4'b0, bit_cnt_o}, 8'd8);
    check("size0 pulses", 8'(valid_cnt - v0), 8'd1);
    v0 = valid_cnt;
    start_frame(1'b1, 1'b0, 4'd12, 8'h96);
    run_edges(8);
    finish_frame;
    check("size12 rx_data", last_rx, 8'h96);
    check("size12 bit_cnt", {4'b0, bit_cnt_o}, 8'd8);
    check("size12 pulses", 8'(valid_cnt - v0), 8'd1);

    $display("[TB] back-to-back frames, mode 1");
    v0 = valid_cnt;
    start_frame(1'b0, 1'b1, 4'd8, 8'h3C);
    run_edges(8);
    tick;
    tick;
    check("b2b capture strobe", {7'b0, rx_valid_o}, 8'h01);
    check("b2b first word", rx_data_o, 8'h3C);
    seq_first = mosi_seq;
    tx_data   = 8'hC3;
    tx_load   = 1'b1;
    tick;
    tx_load  = 1'b0;
    mosi_seq = 8'h00;
    run_edges(8);
    finish_frame;
    check("b2b mosi seq 1", seq_first, 8'h3C);
    check("b2b mosi seq 2", mosi_seq, 8'hC3);
    check("b2b second word", last_rx, 8'hC3);
    check("b2b pulses", 8'(valid_cnt - v0), 8'd2);

    $display("[TB] overrun");
    check("ovr before", {7'b0, rx_overrun_o}, 8'h00);
    rx_fifo_full = 1'b1;
    v0 = valid_cnt;
    start_frame(1'b0, 1'b0, 4'd8, 8'h81);
    run_edges(8);
    finish_frame;
    check("ovr set", {7'b0, rx_overrun_o}, 8'h01);
    check("ovr still pulsed", 8'(valid_cnt - v0), 8'd1);
    check("ovr word", last_rx, 8'h81);
    rx_fifo_full = 1'b0;
    repeat (3) tick;
    check("ovr sticky", {7'b0, rx_overrun_o}, 8'h01);
    rx_overrun_clr = 1'b1;
    tick;
    rx_overrun_clr = 1'b0;
    check("ovr cleared", {7'b0, rx_overrun_o}, 8'h00);

    $display("[TB] abort after 3 samples");
    v0 = valid_cnt;
    start_frame(1'b0, 1'b0, 4'd8, 8'hFF);
    run_edges(3);
    tick;
    tick;
    check("abort bit_cnt", {4'b0, bit_cnt_o}, 8'd3);
    check("abort mosi before", {7'b0, mosi_o}, 8'h01);
    spi_active_i = 1'b0;
    tick;
    tick;
    check("abort mosi", {7'b0, mosi_o}, 8'h00);
    spi_active_i = 1'b1;
    run_edges(2);
    tick;
    tick;
    check("abort idle mosi", {7'b0, mosi_o}, 8'h00);
    check("abort no pulse", 8'(valid_cnt - v0), 8'd0);
    spi_active_i = 1'b0;
    tick;

    $display("[TB] mode 1, N=4, 0x6 loopback");
    v0 = valid_cnt;
    start_frame(1'b0, 1'b1, 4'd4, 8'h06);
    run_edges(4);
    finish_frame;
    check("n4 mosi seq", mosi_seq, 8'h06);
    check("n4 rx_data", last_rx, 8'h06);
    check("n4 pulses", 8'(valid_cnt - v0), 8'd1);

    $display("[TB] reset mid-frame");
    v0 = valid_cnt;
    start_frame(1'b0, 1'b0, 4'd8, 8'hFF);
    run_edges(2);
    tick;
    #2;
    rst_n = 1'b0;
    #1;
    check("rst mosi", {7'b0, mosi_o}, 8'h00);
    check("rst bit_cnt", {4'b0, bit_cnt_o}, 8'h00);
    check("rst rx_data", rx_data_o, 8'h00);
    check("rst rx_valid", {7'b0, rx_valid_o}, 8'h00);
    tick;
    tick;
    rst_n        = 1'b1;
    spi_active_i = 1'b0;
    repeat (3) tick;
    check("rst no pulse", 8'(valid_cnt - v0), 8'd0);
    check("rst overrun", {7'b0, rx_overrun_o}, 8'h00);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
